// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling, valid/ready byte output, framing and overrun flags
module uart_rx #(
    parameter int CLK_FRQ    = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TICK_DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [OS_W-1:0]        os_q, os_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   tick;

    assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        os_d        = os_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                // Clearing the divider here aligns every later tick to the start edge.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                    div_d   = '0;
                    os_d    = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
                        os_d    = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_d    = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                            // A byte accepted this very cycle frees the slot for the new one.
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BRK;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            div_q       <= '0;
            os_q        <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            div_q       <= div_d;
            os_q        <= os_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule
